// File: rtl/regs_wb_queue.sv
// regs_wb_queue: in-order writeback buffer in front of the 32x32 register file, with two-port forwarding.
//   in_valid/in_ready/in_addr/in_data : writeback request handshake (r0 requests are accepted and dropped)
//   rf_gnt/rf_we/rf_waddr/rf_wdata    : register file write port, one retirement per granted cycle
//   fwd_addr_*/fwd_hit_*/fwd_data_*   : combinational lookup of the newest pending write per read port
//   count                             : number of pending entries
module regs_wb_queue #(
  parameter int DEPTH = 4,
  parameter int DW    = 32,
  parameter int AW    = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [AW-1:0]            in_addr,
  input  logic [DW-1:0]            in_data,
  input  logic                     rf_gnt,
  output logic                     rf_we,
  output logic [AW-1:0]            rf_waddr,
  output logic [DW-1:0]            rf_wdata,
  input  logic [AW-1:0]            fwd_addr_a,
  input  logic [AW-1:0]            fwd_addr_b,
  output logic                     fwd_hit_a,
  output logic [DW-1:0]            fwd_data_a,
  output logic                     fwd_hit_b,
  output logic [DW-1:0]            fwd_data_b,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int PW = $clog2(DEPTH);
  logic [AW-1:0]    r_addr [DEPTH];
  logic [DW-1:0]    r_data [DEPTH];
  logic [DEPTH-1:0] r_vld;
  logic [PW-1:0]    r_head, r_tail;
  logic [PW:0]      r_count;
  logic             w_push, w_pop;
  logic [AW-1:0]    w_fa [2];
  logic [1:0]       w_hit;
  logic [DW-1:0]    w_fd [2];
  // count never exceeds DEPTH (a power of two), so its MSB alone flags full
  assign in_ready = !r_count[PW];
  assign w_push   = in_valid && in_ready && (in_addr != '0);
  assign w_pop    = (r_count != '0) && rf_gnt;
  assign rf_we    = w_pop;
  assign rf_waddr = (r_count != '0) ? r_addr[r_head] : '0;
  assign rf_wdata = (r_count != '0) ? r_data[r_head] : '0;
  assign count    = r_count;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_vld   <= '0;
    end else begin
      if (w_push) r_tail <= r_tail + 1'b1;
      if (w_pop) r_head <= r_head + 1'b1;
      r_count <= r_count + (PW+1)'(w_push) - (PW+1)'(w_pop);
      // push and pop never target the same slot: that needs head==tail, i.e. empty or full
      r_vld   <= (r_vld & ~(DEPTH'(w_pop) << r_head)) | (DEPTH'(w_push) << r_tail);
    end
  end
  // payload needs no reset: it is only observed through valid bits or a nonzero count
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_addr[r_tail] <= in_addr;
      r_data[r_tail] <= in_data;
    end
  end
  assign w_fa[0] = fwd_addr_a;
  assign w_fa[1] = fwd_addr_b;
  // scan oldest to newest from head so the last match (newest entry) wins
  always_comb begin
    w_hit   = '0;
    w_fd[0] = '0;
    w_fd[1] = '0;
    for (int p = 0; p < 2; p++) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (r_vld[r_head + PW'(i)] && (r_addr[r_head + PW'(i)] == w_fa[p]) && (w_fa[p] != '0)) begin
          w_hit[p] = 1'b1;
          w_fd[p]  = r_data[r_head + PW'(i)];
        end
      end
    end
  end
  assign fwd_hit_a  = w_hit[0];
  assign fwd_data_a = w_fd[0];
  assign fwd_hit_b  = w_hit[1];
  assign fwd_data_b = w_fd[1];
endmodule

// File: tb/tb_regs_wb_queue.sv
// tb_regs_wb_queue: scoreboard bench for regs_wb_queue; accepted requests must retire in order, nothing else may be written.
module tb_regs_wb_queue;
  localparam int DEPTH = 4, DW = 32, AW = 5;
  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } ent_t;
  logic clk = 1'b0, rst = 1'b1;
  logic in_valid = 1'b0, in_ready, rf_gnt = 1'b0, rf_we;
  logic [AW-1:0] in_addr = '0, rf_waddr, fwd_addr_a = '0, fwd_addr_b = '0;
  logic [DW-1:0] in_data = '0, rf_wdata, fwd_data_a, fwd_data_b;
  logic fwd_hit_a, fwd_hit_b;
  logic [$clog2(DEPTH):0] count;
  int n_chk = 0, n_err = 0;
  ent_t sb[$];
  ent_t e;
  logic s_push = 1'b0, s_pop = 1'b0;
  ent_t s_pe, s_we;
  regs_wb_queue #(.DEPTH(DEPTH), .DW(DW), .AW(AW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr), .in_data(in_data),
    .rf_gnt(rf_gnt), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .fwd_addr_a(fwd_addr_a), .fwd_addr_b(fwd_addr_b), .fwd_hit_a(fwd_hit_a), .fwd_data_a(fwd_data_a),
    .fwd_hit_b(fwd_hit_b), .fwd_data_b(fwd_data_b), .count(count)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic enq(input logic [AW-1:0] a, input logic [DW-1:0] d);
    in_valid = 1'b1;
    in_addr  = a;
    in_data  = d;
    cyc();
    in_valid = 1'b0;
  endtask
  always @(negedge clk) begin
    s_push = in_valid && in_ready && (in_addr != '0);
    s_pe   = '{in_addr, in_data};
    s_pop  = rf_we;
    s_we   = '{rf_waddr, rf_wdata};
  end
  always @(posedge clk) begin
    if (!rst) begin
      if (s_pop) begin
        chk("sb_avail", 64'(sb.size() != 0), 64'd1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          chk("wr_addr", 64'(s_we.a), 64'(e.a));
          chk("wr_data", 64'(s_we.d), 64'(e.d));
        end
      end
      if (s_push) sb.push_back(s_pe);
    end
    s_push = 1'b0;
    s_pop  = 1'b0;
  end
  always @(posedge rst) begin
    sb.delete();
    s_push = 1'b0;
    s_pop  = 1'b0;
  end
  initial begin
    rf_gnt = 1'b1;
    repeat (2) cyc();
    chk("rst_ready", 64'(in_ready), 64'd1);
    chk("rst_we", 64'(rf_we), 64'd0);
    chk("rst_waddr", 64'(rf_waddr), 64'd0);
    chk("rst_wdata", 64'(rf_wdata), 64'd0);
    chk("rst_count", 64'(count), 64'd0);
    rst = 1'b0;
    rf_gnt = 1'b0;
    fwd_addr_a = 5'd3;
    cyc();
    chk("idle_hit_a", 64'(fwd_hit_a), 64'd0);
    chk("idle_hit_b", 64'(fwd_hit_b), 64'd0);
    chk("idle_data_a", 64'(fwd_data_a), 64'd0);
    enq(5'd5, 32'h1234_5678);
    fwd_addr_a = 5'd5;
    #1;
    chk("fwd5_hit", 64'(fwd_hit_a), 64'd1);
    chk("fwd5_data", 64'(fwd_data_a), 64'h1234_5678);
    chk("fwd5_count", 64'(count), 64'd1);
    rf_gnt = 1'b1;
    #1;
    chk("g5_we", 64'(rf_we), 64'd1);
    chk("g5_waddr", 64'(rf_waddr), 64'd5);
    chk("g5_retiring_hit", 64'(fwd_hit_a), 64'd1);
    cyc();
    rf_gnt = 1'b0;
    #1;
    chk("g5_count", 64'(count), 64'd0);
    chk("g5_hit_gone", 64'(fwd_hit_a), 64'd0);
    chk("g5_we_off", 64'(rf_we), 64'd0);
    enq(5'd7, 32'hA);
    enq(5'd7, 32'hB);
    fwd_addr_b = 5'd7;
    fwd_addr_a = 5'd7;
    #1;
    chk("dup_hit_b", 64'(fwd_hit_b), 64'd1);
    chk("dup_newest_b", 64'(fwd_data_b), 64'hB);
    chk("dup_newest_a", 64'(fwd_data_a), 64'hB);
    rf_gnt = 1'b1;
    #1;
    chk("dup_first", 64'(rf_wdata), 64'hA);
    cyc();
    chk("dup_second", 64'(rf_wdata), 64'hB);
    chk("dup_count1", 64'(count), 64'd1);
    chk("dup_fwd_mid", 64'(fwd_data_b), 64'hB);
    cyc();
    rf_gnt = 1'b0;
    #1;
    chk("dup_count0", 64'(count), 64'd0);
    for (int i = 1; i <= 4; i++) enq(AW'(i), 32'h100 + DW'(i));
    fwd_addr_a = 5'd3;
    fwd_addr_b = 5'd6;
    #1;
    chk("full_count", 64'(count), 64'd4);
    chk("full_ready", 64'(in_ready), 64'd0);
    chk("full_fwd3", 64'(fwd_data_a), 64'h103);
    chk("full_miss6", 64'(fwd_hit_b), 64'd0);
    in_valid = 1'b1;
    in_addr  = 5'd9;
    in_data  = 32'hDEAD;
    rf_gnt   = 1'b1;
    #1;
    chk("full_pop_ready", 64'(in_ready), 64'd0);
    chk("full_pop_we", 64'(rf_we), 64'd1);
    chk("full_pop_waddr", 64'(rf_waddr), 64'd1);
    cyc();
    in_valid = 1'b0;
    rf_gnt   = 1'b0;
    #1;
    chk("after_pop_count", 64'(count), 64'd3);
    chk("after_pop_ready", 64'(in_ready), 64'd1);
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      in_addr  = AW'(10 + i);
      in_data  = 32'hC0DE_0000 + DW'(i);
      rf_gnt   = 1'b1;
      cyc();
    end
    in_valid = 1'b0;
    chk("stream_count", 64'(count), 64'd3);
    for (int k = 0; k < 20 && count != 0; k++) cyc();
    rf_gnt = 1'b0;
    chk("drained", 64'(count), 64'd0);
    chk("r0_ready", 64'(in_ready), 64'd1);
    enq(5'd0, 32'hFFFF_FFFF);
    fwd_addr_a = 5'd0;
    rf_gnt = 1'b1;
    #1;
    chk("r0_count", 64'(count), 64'd0);
    chk("r0_hit", 64'(fwd_hit_a), 64'd0);
    chk("r0_we", 64'(rf_we), 64'd0);
    repeat (2) cyc();
    rf_gnt = 1'b0;
    for (int i = 0; i < 3; i++) enq(AW'(21 + i), 32'h5500 + DW'(i));
    fwd_addr_a = 5'd21;
    #1;
    chk("pre_rst_count", 64'(count), 64'd3);
    chk("pre_rst_hit", 64'(fwd_hit_a), 64'd1);
    #2;
    rst = 1'b1;
    rf_gnt = 1'b1;
    #1;
    chk("arst_count", 64'(count), 64'd0);
    chk("arst_we", 64'(rf_we), 64'd0);
    chk("arst_hit", 64'(fwd_hit_a), 64'd0);
    chk("arst_ready", 64'(in_ready), 64'd1);
    repeat (2) cyc();
    #3;
    rst = 1'b0;
    repeat (5) cyc();
    chk("post_rst_count", 64'(count), 64'd0);
    chk("post_rst_we", 64'(rf_we), 64'd0);
    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/regs_wb_queue.md
Name: regs_wb_queue

Overview:
- Write-side front end for the 32x32 register file.
- Accepts writeback requests from the datapath over a valid/ready handshake and buffers them in a DEPTH-entry in-order FIFO.
- Retires one entry per granted cycle onto the register file write port (Write_Reg/W_Addr/W_Data).
- Provides two-port forwarding lookup: operand reads see pending, not-yet-written data.

Parameters:
DEPTH, 4, number of buffered writeback entries (power of two, >=2)
DW, 32, data width of a register
AW, 5, register address width

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  reset; asynchronous, active-high
in_valid  input  1  writeback request present
in_ready  output  1  queue can accept a request this cycle
in_addr  input  AW  destination register of request
in_data  input  DW  data of request
rf_gnt  input  1  register file write port available this cycle
rf_we  output  1  drives register file Write_Reg
rf_waddr  output  AW  drives register file W_Addr
rf_wdata  output  DW  drives register file W_Data
fwd_addr_a  input  AW  port A operand address (same as R_Addr_A)
fwd_addr_b  input  AW  port B operand address (same as R_Addr_B)
fwd_hit_a  output  1  pending entry matches fwd_addr_a
fwd_data_a  output  DW  newest pending data for fwd_addr_a
fwd_hit_b  output  1  pending entry matches fwd_addr_b
fwd_data_b  output  DW  newest pending data for fwd_addr_b
count  output  clog2(DEPTH)+1  number of valid entries

Behaviour:
- Reset is asynchronous on rst high: count=0, head/tail pointers=0, all entry valid bits cleared.
  - Outputs during and after reset: in_ready=1, rf_we=0, rf_waddr=0, rf_wdata=0, fwd_hit_a/b=0, fwd_data_a/b=0.
  - Reset mid-operation discards all pending entries; none are written to the register file.
- Enqueue: in_ready = (count < DEPTH). Handshake completes when in_valid && in_ready at the rising edge.
  - in_addr != 0: entry stored at tail, tail increments mod DEPTH.
  - in_addr == 0: handshake completes but nothing is stored (count unchanged), because r0 is hardwired zero.
- Dequeue: rf_we = (count != 0) && rf_gnt, combinational.
  - rf_waddr/rf_wdata = head entry when count != 0, else 0.
  - When rf_we is high, head increments mod DEPTH at the edge; the register file captures the write at the same edge.
- Simultaneous enqueue and dequeue in one cycle: count unchanged, both pointers advance.
  - Full plus dequeue does not raise in_ready in the same cycle; in_ready is based on registered count only, with no pass-through.
- Ordering: strictly in order. Duplicate addresses are all written in order (no merging), so the last write wins in the register file.
- Forwarding is combinational and covers stored entries only; same-cycle in_* is not forwarded.
  - Matching is newest-first over valid entries; the most recently enqueued match is selected.
  - The head entry retiring this cycle still counts as a hit. After the edge its data is in the register file and it is no longer pending.
  - fwd_addr == 0: hit=0, data=0.
  - No match: hit=0, data=0.
  - Consumer selects fwd_data when hit, else the register file read data.
- Latency: a request accepted at edge N is visible on the forwarding ports after edge N.
  - It is written to the register file at the first edge >= N+1 where it is head and rf_gnt=1.
  - Minimum enqueue-to-write latency: 1 cycle.
- Pointer wrap-around: pointers are clog2(DEPTH) bits and wrap naturally. count disambiguates full from empty.
- Enqueue with in_valid low, or while full, changes no state. in_addr/in_data are ignored when not accepted.

Test Plan:
- Reset then idle -> in_ready=1, count=0, rf_we=0, fwd_hit_a/b=0 with fwd_addr_a=3.
- Enqueue (addr 5, 0x1234_5678) with rf_gnt=0, then fwd_addr_a=5 -> fwd_hit_a=1, fwd_data_a=0x12345678, count=1. Raise rf_gnt -> rf_we=1, rf_waddr=5 for one cycle, then count=0 and fwd_hit_a=0.
- Enqueue addr 7=0xA then addr 7=0xB, rf_gnt=0, fwd_addr_b=7 -> fwd_data_b=0xB. Grant -> writes 0xA then 0xB on consecutive cycles.
- Fill 4 entries (addrs 1..4), rf_gnt=0 -> count=4, in_ready=0, and a 5th in_valid is not accepted. One grant -> count=3, in_ready=1 next cycle. Refill plus drain 8 more entries to exercise pointer wrap, with write order matching enqueue order.
- Enqueue addr 0 data 0xFFFF_FFFF -> handshake completes, count stays 0, rf_we never asserts. fwd_addr_a=0 -> hit=0.
- With 3 entries pending, assert rst asynchronously mid-cycle -> count=0, rf_we=0, and no writes after rst deasserts even with rf_gnt=1.
